// File: rtl/out_port_tx_pkg.sv
// out_port_tx_pkg
//   Shared definitions for the output-port serial transmitter: FSM state
//   encoding, serial frame constants and the default bit period.
package out_port_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic       START_BIT      = 1'b0;
  localparam logic       STOP_BIT       = 1'b1;
  localparam int         DATA_BITS      = 16;
  localparam logic [3:0] LAST_BIT       = 4'(DATA_BITS - 1);
  localparam int         BIT_CYCLES_DEF = 4;

endpackage

// File: rtl/port_fifo.sv
// port_fifo
//   Synchronous FIFO holding output-port words awaiting transmission.
//   A push to a full FIFO is accepted only if a pop happens at the same edge.
// Ports:
//   i_clk, i_rst_n     clock, async active-low reset
//   i_push, i_data     write strobe and 16-bit word
//   i_pop              remove head word (ignored when empty)
//   o_data             head word
//   o_full, o_empty    occupancy flags
//   o_level            occupancy, 0..DEPTH
module port_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [15:0]            i_data,
  input  logic                   i_pop,
  output logic [15:0]            o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop at the same edge frees a slot, so a full FIFO can still take the write.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/out_port_tx.sv
// out_port_tx
//   Buffers processor output-port words in a FIFO and sends each one as a
//   serial frame: start bit (0), 16 data bits LSB-first, stop bit (1), every
//   bit held BIT_CYCLES clocks. Frames run back-to-back while words remain.
// Ports:
//   clk, reset         clock, async active-low reset
//   outPortData        word to queue
//   outSignalEn        write strobe, one word per high cycle
//   txSerial           registered serial line, idles high
//   busy               frame in progress
//   fifoFull           FIFO holds DEPTH words
//   overflow           sticky: a write was dropped
//   level              FIFO occupancy
//
// state    | meaning
// ST_IDLE  | line high, waiting for a queued word
// ST_START | start bit on the line
// ST_DATA  | data bit r_bit on the line
// ST_STOP  | stop bit; at its end pop the next word or go idle
module out_port_tx
  import out_port_tx_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            outPortData,
  input  logic                   outSignalEn,
  output logic                   txSerial,
  output logic                   busy,
  output logic                   fifoFull,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CYC_LOAD = CW'(BIT_CYCLES - 1);

  tx_state_e             r_state;
  logic [DATA_BITS-1:0]  r_shift;
  logic [3:0]            r_bit;
  logic [CW-1:0]         r_cyc;
  logic                  r_tx;
  logic                  r_ovf;

  logic [15:0]           w_head;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_cyc_tc;
  logic                  w_pop;
  logic [$clog2(DEPTH):0] w_level;

  assign w_cyc_tc = (r_cyc == '0);
  // Pop when leaving IDLE or when a stop bit completes with more words queued.
  assign w_pop    = !w_empty && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_STOP) && w_cyc_tc));

  port_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (outSignalEn),
    .i_data  (outPortData),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_cyc   <= '0;
      r_tx    <= STOP_BIT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= STOP_BIT;
          if (w_pop) begin
            r_shift <= w_head;
            r_cyc   <= CYC_LOAD;
            r_tx    <= START_BIT;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_cyc_tc) begin
            r_bit   <= '0;
            r_cyc   <= CYC_LOAD;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_cyc <= r_cyc - 1'b1;
          end
        end
        ST_DATA: begin
          if (w_cyc_tc) begin
            r_cyc <= CYC_LOAD;
            if (r_bit == LAST_BIT) begin
              r_tx    <= STOP_BIT;
              r_state <= ST_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cyc <= r_cyc - 1'b1;
          end
        end
        ST_STOP: begin
          if (w_cyc_tc) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_cyc   <= CYC_LOAD;
              r_tx    <= START_BIT;
              r_state <= ST_START;
            end else begin
              r_tx    <= STOP_BIT;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cyc <= r_cyc - 1'b1;
          end
        end
        default: begin
          r_tx    <= STOP_BIT;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Dropped write: full FIFO with no pop freeing a slot at this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (outSignalEn && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  assign txSerial = r_tx;
  assign busy     = (r_state != ST_IDLE);
  assign fifoFull = w_full;
  assign overflow = r_ovf;
  assign level    = w_level;

endmodule
